match_window_counter: RTL and testbench

- Downstream consumer of the Moore "1001" non-overlapping sequence detector. Its single-cycle match flag `z` arrives on `z_in`.
- Counts detector matches over fixed windows of WINDOW_LEN cycles and presents each window's count through a valid/ready output register.
- Keeps a sticky overrun flag and a saturating lifetime match total for status readout.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/match_window_counter.sv | 155 +++++++++++++++
 tb/tb_match_window_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the "1001" detector and its downstream match counter.
package seq_det_pkg;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_e;

  localparam int unsigned WINDOW_LEN_DEF = 16;
  localparam int unsigned CNT_W_DEF      = 4;
  localparam int unsigned TOT_W_DEF      = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; o_sat flags the count sitting at its maximum.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_sat
);

  localparam logic [W-1:0] Max = '1;

  logic [W-1:0] r_count;

  // Clear has priority over increment; increment holds at the maximum.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != Max)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = (r_count == Max);

endmodule

// File: rtl/match_window_counter.sv
// Counts detector matches over fixed windows and hands each window result out through a
// valid/ready register; also keeps a sticky overrun flag and a saturating lifetime total.
module match_window_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = WINDOW_LEN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TOT_W      = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             z_in,
  input  logic             ovr_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             overrun,
  output logic [TOT_W-1:0] total_matches
);

  localparam int unsigned     WinW    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_LEN - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [WinW-1:0]  r_win_cnt;
  logic             r_win_sat;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_sat;
  logic             r_overrun;

  logic             w_sampled;
  logic             w_abort;
  logic             w_win_end;
  logic             w_match_clr;
  logic             w_match_inc;
  logic [CNT_W-1:0] w_match_cnt;
  logic             w_match_full;
  logic [CNT_W-1:0] w_res_count;
  logic             w_res_sat;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_tot_inc;
  logic             w_tot_full;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state: en starts and aborts windows; the IDLE->RUN cycle is not sampled.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (en)  w_state_d = RUN;
      RUN:     if (!en) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  assign w_sampled = (r_state == RUN) && en;
  assign w_abort   = (r_state == RUN) && !en;
  assign w_win_end = w_sampled && (r_win_cnt == WinLast);

  // Position within the current window; wraps with no gap between windows.
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_win_cnt <= '0;
    end else if (w_sampled) begin
      r_win_cnt <= w_win_end ? '0 : r_win_cnt + WinW'(1);
    end
  end

  assign w_match_clr = w_abort || w_win_end;
  assign w_match_inc = w_sampled && z_in;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_match_clr),
    .i_inc  (w_match_inc),
    .o_count(w_match_cnt),
    .o_sat  (w_match_full)
  );

  // Window saturation bit: set when a match arrives with the count already at maximum.
  always_ff @(posedge clk) begin
    if (rst || w_match_clr) begin
      r_win_sat <= 1'b0;
    end else if (w_match_inc && w_match_full) begin
      r_win_sat <= 1'b1;
    end
  end

  // Window result folds in the final cycle's z_in, since the counter clears on that edge.
  assign w_res_count = (z_in && !w_match_full) ? w_match_cnt + CNT_W'(1) : w_match_cnt;
  assign w_res_sat   = r_win_sat || (z_in && w_match_full);

  assign w_accept    = r_out_valid && out_ready;
  assign w_slot_free = !r_out_valid || out_ready;

  // Output slot: load on a free window end, otherwise drop valid on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_win_end && w_slot_free) begin
      r_out_valid <= 1'b1;
      r_out_count <= w_res_count;
      r_out_sat   <= w_res_sat;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop in the same cycle as ovr_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_win_end && !w_slot_free) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_tot_inc = w_sampled && z_in && !w_tot_full;

  sat_counter #(
    .W(TOT_W)
  ) u_total_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (1'b0),
    .i_inc  (w_tot_inc),
    .o_count(total_matches),
    .o_sat  (w_tot_full)
  );

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter: default instance plus a TOT_W=4 instance.
module tb_match_window_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        z_in;
  logic        ovr_clr;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_count;
  logic        out_sat;
  logic        overrun;
  logic [15:0] total_matches;

  logic        s_out_valid;
  logic [3:0]  s_out_count;
  logic        s_out_sat;
  logic        s_overrun;
  logic [3:0]  s_total;

  int n_pass;
  int n_total;

  match_window_counter #(
    .WINDOW_LEN(16),
    .CNT_W     (4),
    .TOT_W     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .z_in         (z_in),
    .ovr_clr      (ovr_clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_sat      (out_sat),
    .overrun      (overrun),
    .total_matches(total_matches)
  );

  match_window_counter #(
    .WINDOW_LEN(16),
    .CNT_W     (4),
    .TOT_W     (4)
  ) dut_small (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .z_in         (z_in),
    .ovr_clr      (ovr_clr),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_count    (s_out_count),
    .out_sat      (s_out_sat),
    .overrun      (s_overrun),
    .total_matches(s_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied before the edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; z_in = 1'b0; ovr_clr = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run();
    en = 1'b1; z_in = 1'b0;
    tick();
  endtask

  // Drives one window; pattern bit k is z_in at sampled cycle k.
  task automatic run_window(input logic [15:0] pat);
    for (int k = 0; k < 16; k++) begin
      z_in = pat[k];
      tick();
    end
    z_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ovr_clr = 1'b0; out_ready = 1'b0;
    z_in = 1'b1; tick();
    z_in = 1'b0; tick();
    n_total++;
    if ({out_valid, out_count, out_sat, overrun, total_matches} !== 23'd0)
      $display("FAIL reset_outputs: got v=%b c=%0d s=%b o=%b t=%0d want all 0",
               out_valid, out_count, out_sat, overrun, total_matches);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      z_in = i[0] ? 1'b0 : 1'b1;
      tick();
    end
    z_in = 1'b0;
    n_total++;
    if (total_matches !== 16'd0 || out_valid !== 1'b0)
      $display("FAIL idle_ignores_z: got t=%0d v=%b want t=0 v=0", total_matches, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic_window();
    do_reset();
    out_ready = 1'b1;
    start_run();
    for (int k = 0; k < 16; k++) begin
      z_in = (k == 3 || k == 7 || k == 12) ? 1'b1 : 1'b0;
      tick();
      if (k == 14) begin
        n_total++;
        if (out_valid !== 1'b0)
          $display("FAIL basic_early_valid: got v=%b want 0", out_valid);
        else n_pass++;
      end
    end
    z_in = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd3 || out_sat !== 1'b0)
      $display("FAIL basic_result: got v=%b c=%0d s=%b want v=1 c=3 s=0",
               out_valid, out_count, out_sat);
    else n_pass++;
    n_total++;
    if (total_matches !== 16'd3)
      $display("FAIL basic_total: got %0d want 3", total_matches);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_one_cycle: got v=%b want 0", out_valid);
    else n_pass++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    start_run();
    run_window(16'h0011);
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd2 || overrun !== 1'b0)
      $display("FAIL bp_window_a: got v=%b c=%0d o=%b want v=1 c=2 o=0",
               out_valid, out_count, overrun);
    else n_pass++;
    run_window(16'h0155);
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd2 || overrun !== 1'b1)
      $display("FAIL bp_window_b: got v=%b c=%0d o=%b want v=1 c=2 o=1",
               out_valid, out_count, overrun);
    else n_pass++;
    n_total++;
    if (total_matches !== 16'd7)
      $display("FAIL bp_total: got %0d want 7", total_matches);
    else n_pass++;
    en = 1'b0; out_ready = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || overrun !== 1'b1)
      $display("FAIL bp_accept: got v=%b o=%b want v=0 o=1", out_valid, overrun);
    else n_pass++;
    out_ready = 1'b0; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_total++;
    if (overrun !== 1'b0)
      $display("FAIL bp_ovr_clr: got o=%b want 0", overrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    start_run();
    run_window(16'h0100);
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd1)
      $display("FAIL b2b_first: got v=%b c=%0d want v=1 c=1", out_valid, out_count);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      z_in = (k == 0 || k == 5 || k == 10 || k == 15) ? 1'b1 : 1'b0;
      out_ready = (k == 15) ? 1'b1 : 1'b0;
      tick();
      if (k == 14) begin
        n_total++;
        if (out_valid !== 1'b1 || out_count !== 4'd1)
          $display("FAIL b2b_hold: got v=%b c=%0d want v=1 c=1", out_valid, out_count);
        else n_pass++;
      end
    end
    z_in = 1'b0; out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd4 || overrun !== 1'b0)
      $display("FAIL b2b_load: got v=%b c=%0d o=%b want v=1 c=4 o=0",
               out_valid, out_count, overrun);
    else n_pass++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    start_run();
    run_window(16'hFFFF);
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd15 || out_sat !== 1'b1)
      $display("FAIL sat_window: got v=%b c=%0d s=%b want v=1 c=15 s=1",
               out_valid, out_count, out_sat);
    else n_pass++;
    n_total++;
    if (total_matches !== 16'd16 || s_total !== 4'd15)
      $display("FAIL sat_total16: got t=%0d ts=%0d want t=16 ts=15", total_matches, s_total);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      z_in = 1'b1;
      tick();
    end
    z_in = 1'b0; en = 1'b0;
    tick();
    n_total++;
    if (total_matches !== 16'd20 || s_total !== 4'd15 || out_valid !== 1'b0)
      $display("FAIL sat_total20: got t=%0d ts=%0d v=%b want t=20 ts=15 v=0",
               total_matches, s_total, out_valid);
    else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    out_ready = 1'b1;
    start_run();
    for (int k = 0; k < 5; k++) begin
      z_in = (k == 1 || k == 3) ? 1'b1 : 1'b0;
      tick();
    end
    z_in = 1'b1; en = 1'b0;
    tick();
    z_in = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_total++;
    if (out_valid !== 1'b0 || total_matches !== 16'd2)
      $display("FAIL abort_no_output: got v=%b t=%0d want v=0 t=2", out_valid, total_matches);
    else n_pass++;
    start_run();
    run_window(16'h0040);
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd1 || total_matches !== 16'd3)
      $display("FAIL abort_restart: got v=%b c=%0d t=%0d want v=1 c=1 t=3",
               out_valid, out_count, total_matches);
    else n_pass++;
    en = 1'b0;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1; en = 1'b0; z_in = 1'b0; ovr_clr = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_window();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
